// File: rtl/npc_lsu_bridge.sv
// ---------------------------------------------------------------------------
// npc_lsu_bridge
//
// Handshaked load/store unit sitting between the MEM stage and the
// DRAM/peripheral bus. One request is in flight at a time. Each request is
// checked for alignment, launched onto the bus for one cycle, optionally
// waits a fixed read/write latency, and completes with a one-cycle response.
// Load data is lane-extracted and sign/zero extended.
//
// Ports:
//   clk, rst          core clock, asynchronous active-low reset
//   req_*             MEM stage request (valid/ready handshake)
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores/errors), held
//   resp_err          misaligned access or reserved size (with resp_valid)
//   busy              request accepted but response not yet given
//   perip_addr/mask   bus address and size code, held between accesses
//   perip_wen         write strobe, high for the single store launch cycle
//   perip_wdata       store data
//   perip_rdata       aligned word at perip_addr & ~3
// ---------------------------------------------------------------------------
module npc_lsu_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] perip_addr,
  output logic              perip_wen,
  output logic [1:0]        perip_mask,
  output logic [DATA_W-1:0] perip_wdata,
  input  logic [DATA_W-1:0] perip_rdata
);

  // Elaboration-time parameter checks.
  if (DATA_W != 32) begin : g_bad_data_w
    $error("npc_lsu_bridge: DATA_W must be 32");
  end
  if (RD_LAT < 0 || RD_LAT > 7) begin : g_bad_rd_lat
    $error("npc_lsu_bridge: RD_LAT must be in 0..7");
  end
  if (WR_LAT < 0 || WR_LAT > 7) begin : g_bad_wr_lat
    $error("npc_lsu_bridge: WR_LAT must be in 0..7");
  end

  // Counter preload values: WAIT lasts exactly LAT cycles, ending on count 0.
  localparam logic [2:0] RD_CNT = 3'((RD_LAT > 0) ? RD_LAT - 1 : 0);
  localparam logic [2:0] WR_CNT = 3'((WR_LAT > 0) ? WR_LAT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  logic [1:0]  cap_lane_reg;
  logic [1:0]  cap_size_reg;
  logic        cap_wen_reg;
  logic        cap_uns_reg;

  // -------------------------------------------------------------------------
  // Request checking
  // -------------------------------------------------------------------------
  logic req_bad;
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'd1:    req_bad = req_addr[0];
      2'd2:    req_bad = (req_addr[1:0] != 2'b00);
      2'd3:    req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Load lane extraction from the aligned bus word
  // -------------------------------------------------------------------------
  logic [7:0]  lane_byte [4];
  logic [15:0] lane_half [2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
    assign lane_byte[gi] = perip_rdata[8*gi +: 8];
  end
  for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
    assign lane_half[gi] = perip_rdata[16*gi +: 16];
  end

  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [DATA_W-1:0] load_data;

  always_comb begin
    sel_byte  = lane_byte[cap_lane_reg];
    sel_half  = lane_half[cap_lane_reg[1]];
    load_data = perip_rdata;
    case (cap_size_reg)
      2'd0: load_data = cap_uns_reg ? {{(DATA_W-8){1'b0}}, sel_byte}
                                    : {{(DATA_W-8){sel_byte[7]}}, sel_byte};
      2'd1: load_data = cap_uns_reg ? {{(DATA_W-16){1'b0}}, sel_half}
                                    : {{(DATA_W-16){sel_half[15]}}, sel_half};
      default: load_data = perip_rdata;
    endcase
  end

  // Data placed on resp_rdata at completion: stores return zero.
  logic [DATA_W-1:0] done_data;
  assign done_data = cap_wen_reg ? '0 : load_data;

  // -------------------------------------------------------------------------
  // Control FSM. Everything the bus and the pipeline see is registered so the
  // async reset removes the write strobe immediately.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      cap_lane_reg <= '0;
      cap_size_reg <= '0;
      cap_wen_reg  <= 1'b0;
      cap_uns_reg  <= 1'b0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      perip_addr   <= '0;
      perip_wen    <= 1'b0;
      perip_mask   <= '0;
      perip_wdata  <= '0;
    end else begin
      // Single-cycle pulses default low.
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      perip_wen  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            cap_lane_reg <= req_addr[1:0];
            cap_size_reg <= req_size;
            cap_wen_reg  <= req_wen;
            cap_uns_reg  <= req_unsigned;
            if (req_bad) begin
              // Trapped requests never touch the bus.
              state_reg  <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state_reg   <= ACCESS;
              perip_addr  <= req_addr;
              perip_mask  <= req_size;
              perip_wdata <= req_wdata;
              perip_wen   <= req_wen;
            end
          end
        end

        ACCESS: begin
          if (cap_wen_reg) begin
            if (WR_LAT > 0) begin
              cnt_reg   <= WR_CNT;
              state_reg <= WAIT;
            end else begin
              state_reg  <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
            end
          end else begin
            if (RD_LAT == 0) begin
              // Zero-latency bus: data is valid during the launch cycle.
              state_reg  <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
            end else begin
              cnt_reg   <= RD_CNT;
              state_reg <= WAIT;
            end
          end
        end

        WAIT: begin
          if (cnt_reg == 3'd0) begin
            state_reg  <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= done_data;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end

        RESP: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Handshake status is a pure decode of the state register.
  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_npc_lsu_bridge.sv
// ---------------------------------------------------------------------------
// tb_npc_lsu_bridge
//
// Directed bench for npc_lsu_bridge. Instance "a" runs with RD_LAT=1 and
// WR_LAT=2 for the load/store/error/reset sequences; instance "b" runs with
// RD_LAT=0, WR_LAT=0 for back-to-back throughput. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_npc_lsu_bridge;

  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- instance a: RD_LAT=1, WR_LAT=2 ----------------
  logic        a_req_valid, a_req_ready, a_req_wen, a_req_unsigned;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_err, a_busy;
  logic [31:0] a_resp_rdata;
  logic [31:0] a_perip_addr, a_perip_wdata, a_perip_rdata;
  logic        a_perip_wen;
  logic [1:0]  a_perip_mask;

  npc_lsu_bridge #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .WR_LAT(2)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (a_req_valid),
    .req_ready    (a_req_ready),
    .req_wen      (a_req_wen),
    .req_size     (a_req_size),
    .req_unsigned (a_req_unsigned),
    .req_addr     (a_req_addr),
    .req_wdata    (a_req_wdata),
    .resp_valid   (a_resp_valid),
    .resp_rdata   (a_resp_rdata),
    .resp_err     (a_resp_err),
    .busy         (a_busy),
    .perip_addr   (a_perip_addr),
    .perip_wen    (a_perip_wen),
    .perip_mask   (a_perip_mask),
    .perip_wdata  (a_perip_wdata),
    .perip_rdata  (a_perip_rdata)
  );

  // ---------------- instance b: RD_LAT=0, WR_LAT=0 ----------------
  logic        b_req_valid, b_req_ready, b_req_wen, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_err, b_busy;
  logic [31:0] b_resp_rdata;
  logic [31:0] b_perip_addr, b_perip_wdata, b_perip_rdata;
  logic        b_perip_wen;
  logic [1:0]  b_perip_mask;

  npc_lsu_bridge #(.ADDR_W(32), .DATA_W(32), .RD_LAT(0), .WR_LAT(0)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (b_req_valid),
    .req_ready    (b_req_ready),
    .req_wen      (b_req_wen),
    .req_size     (b_req_size),
    .req_unsigned (b_req_unsigned),
    .req_addr     (b_req_addr),
    .req_wdata    (b_req_wdata),
    .resp_valid   (b_resp_valid),
    .resp_rdata   (b_resp_rdata),
    .resp_err     (b_resp_err),
    .busy         (b_busy),
    .perip_addr   (b_perip_addr),
    .perip_wen    (b_perip_wen),
    .perip_mask   (b_perip_mask),
    .perip_wdata  (b_perip_wdata),
    .perip_rdata  (b_perip_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance a (called at a falling edge with a idle)
  // and follow it until resp_valid or a 20-cycle bound.
  task automatic do_req(
    input  string       name,
    input  logic        wen,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output int          lat,
    output logic [31:0] rdata,
    output logic        err,
    output int          wen_cnt,
    output logic [31:0] acc_addr,
    output logic [1:0]  acc_mask,
    output logic [31:0] acc_wdata
  );
    logic found;
    a_req_valid    = 1'b1;
    a_req_wen      = wen;
    a_req_size     = size;
    a_req_unsigned = uns;
    a_req_addr     = addr;
    a_req_wdata    = wdata;
    @(negedge clk);
    a_req_valid = 1'b0;
    found     = 1'b0;
    lat       = 0;
    wen_cnt   = 0;
    rdata     = 32'hx;
    err       = 1'bx;
    acc_addr  = a_perip_addr;
    acc_mask  = a_perip_mask;
    acc_wdata = a_perip_wdata;
    for (int i = 1; i <= 20 && !found; i++) begin
      if (a_perip_wen) begin
        wen_cnt++;
        acc_wdata = a_perip_wdata;
      end
      if (a_resp_valid) begin
        found = 1'b1;
        lat   = i;
        rdata = a_resp_rdata;
        err   = a_resp_err;
      end else begin
        @(negedge clk);
      end
    end
    chk({name, ".resp_seen"}, 32'(found), 32'd1);
    $display("txn %-10s wen=%0d size=%0d uns=%0d addr=0x%08h -> lat=%0d rdata=0x%08h err=%0d wen_pulses=%0d",
             name, wen, size, uns, addr, lat, rdata, err, wen_cnt);
    // Step into the following IDLE cycle; the pulse must be gone.
    @(negedge clk);
    chk({name, ".resp_pulse"}, 32'(a_resp_valid), 32'd0);
  endtask

  int          lat, wen_cnt;
  logic [31:0] rdata, acc_addr, acc_wdata;
  logic        err;
  logic [1:0]  acc_mask;

  initial begin
    rst = 1'b0;
    a_req_valid = 0; a_req_wen = 0; a_req_size = 0; a_req_unsigned = 0;
    a_req_addr = 0; a_req_wdata = 0; a_perip_rdata = 0;
    b_req_valid = 0; b_req_wen = 0; b_req_size = 0; b_req_unsigned = 0;
    b_req_addr = 0; b_req_wdata = 0; b_perip_rdata = 0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk("rst.req_ready",  32'(a_req_ready),  32'd1);
    chk("rst.busy",       32'(a_busy),       32'd0);
    chk("rst.resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst.perip_wen",  32'(a_perip_wen),  32'd0);
    chk("rst.perip_addr", a_perip_addr,      32'd0);
    rst = 1'b1;
    @(negedge clk);

    // ---------------- load word, RD_LAT=1 ----------------
    a_perip_rdata = 32'hDEADBEEF;
    do_req("lw_100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rdata, err, wen_cnt, acc_addr, acc_mask, acc_wdata);
    chk("lw.acc_addr", acc_addr, 32'h100);
    chk("lw.acc_mask", 32'(acc_mask), 32'd2);
    chk("lw.lat",      32'(lat), 32'd3);
    chk("lw.rdata",    rdata, 32'hDEADBEEF);
    chk("lw.err",      32'(err), 32'd0);
    chk("lw.wen",      32'(wen_cnt), 32'd0);

    // ---------------- lane extraction ----------------
    a_perip_rdata = 32'h80FF1234;
    do_req("lb_103", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, lat, rdata, err, wen_cnt, acc_addr, acc_mask, acc_wdata);
    chk("lb103.rdata", rdata, 32'hFFFFFF80);
    chk("lb103.lat",   32'(lat), 32'd3);
    do_req("lbu_103", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, lat, rdata, err, wen_cnt, acc_addr, acc_mask, acc_wdata);
    chk("lbu103.rdata", rdata, 32'h00000080);
    do_req("lh_102", 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, lat, rdata, err, wen_cnt, acc_addr, acc_mask, acc_wdata);
    chk("lh102.rdata", rdata, 32'hFFFF80FF);
    chk("lh102.mask",  32'(acc_mask), 32'd1);
    do_req("lhu_100", 1'b0, 2'd1, 1'b1, 32'h100, 32'h0, lat, rdata, err, wen_cnt, acc_addr, acc_mask, acc_wdata);
    chk("lhu100.rdata", rdata, 32'h00001234);
    do_req("lb_101", 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, lat, rdata, err, wen_cnt, acc_addr, acc_mask, acc_wdata);
    chk("lb101.rdata", rdata, 32'h00000012);
    do_req("lb_102", 1'b0, 2'd0, 1'b0, 32'h102, 32'h0, lat, rdata, err, wen_cnt, acc_addr, acc_mask, acc_wdata);
    chk("lb102.rdata", rdata, 32'hFFFFFFFF);

    // ---------------- store half, WR_LAT=2 ----------------
    do_req("sh_202", 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, lat, rdata, err, wen_cnt, acc_addr, acc_mask, acc_wdata);
    chk("sh.wen_pulses", 32'(wen_cnt), 32'd1);
    chk("sh.addr",       acc_addr, 32'h202);
    chk("sh.mask",       32'(acc_mask), 32'd1);
    chk("sh.wdata",      acc_wdata, 32'h0000ABCD);
    chk("sh.lat",        32'(lat), 32'd4);
    chk("sh.rdata",      rdata, 32'h0);
    chk("sh.err",        32'(err), 32'd0);

    // ---------------- error trapping ----------------
    do_req("lw_101", 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, lat, rdata, err, wen_cnt, acc_addr, acc_mask, acc_wdata);
    chk("mis.lat",   32'(lat), 32'd1);
    chk("mis.err",   32'(err), 32'd1);
    chk("mis.rdata", rdata, 32'h0);
    chk("mis.wen",   32'(wen_cnt), 32'd0);
    chk("mis.addr",  acc_addr, 32'h202);
    chk("mis.addr2", a_perip_addr, 32'h202);
    do_req("sz3_000", 1'b1, 2'd3, 1'b0, 32'h0, 32'h12345678, lat, rdata, err, wen_cnt, acc_addr, acc_mask, acc_wdata);
    chk("sz3.lat",   32'(lat), 32'd1);
    chk("sz3.err",   32'(err), 32'd1);
    chk("sz3.wen",   32'(wen_cnt), 32'd0);
    chk("sz3.addr",  a_perip_addr, 32'h202);
    chk("sz3.mask",  32'(a_perip_mask), 32'd1);

    // ---------------- back-to-back, RD_LAT=0 ----------------
    b_perip_rdata = 32'h11223344;
    b_req_size    = 2'd2;
    b_req_addr    = 32'h40;
    b_req_valid   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("b2b.busy%0d", i),  32'(b_busy),       32'((i % 3) != 0));
      chk($sformatf("b2b.ready%0d", i), 32'(b_req_ready),  32'((i % 3) == 0));
      chk($sformatf("b2b.rv%0d", i),    32'(b_resp_valid), 32'((i % 3) == 2));
      if (i % 3 == 2) begin
        chk($sformatf("b2b.rdata%0d", i), b_resp_rdata, 32'h11223344);
        $display("txn b2b_%0d    load word addr=0x40 -> rdata=0x%08h", i / 3, b_resp_rdata);
      end
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    @(negedge clk);

    // ---------------- reset during store ACCESS ----------------
    a_req_valid = 1'b1; a_req_wen = 1'b1; a_req_size = 2'd2;
    a_req_addr = 32'h300; a_req_wdata = 32'h55;
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("rstmid.wen_before", 32'(a_perip_wen), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rstmid.wen_after",  32'(a_perip_wen),  32'd0);
    chk("rstmid.ready",      32'(a_req_ready),  32'd1);
    chk("rstmid.busy",       32'(a_busy),       32'd0);
    chk("rstmid.addr",       a_perip_addr,      32'd0);
    chk("rstmid.wdata",      a_perip_wdata,     32'd0);
    chk("rstmid.rdata",      a_resp_rdata,      32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rstpost.rv%0d", i),    32'(a_resp_valid), 32'd0);
      chk($sformatf("rstpost.ready%0d", i), 32'(a_req_ready),  32'd1);
    end
    chk("rstpost.mask", 32'(a_perip_mask), 32'd0);
    chk("rstpost.err",  32'(a_resp_err),   32'd0);
    $display("txn rst_abort  store addr=0x300 abandoned in launch cycle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
